// File: rtl/rv_dual_pkg.sv
// Shared types and constants for the dual-issue ID->EX latch.
package rv_dual_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned OPR_W  = 4;

  // ALU opcodes
  localparam logic [OPR_W-1:0] OPR_ADD = 4'b0000;
  localparam logic [OPR_W-1:0] OPR_SUB = 4'b0001;
  localparam logic [OPR_W-1:0] OPR_SLL = 4'b0010;
  localparam logic [OPR_W-1:0] OPR_SLT = 4'b0011;
  localparam logic [OPR_W-1:0] OPR_XOR = 4'b0100;
  localparam logic [OPR_W-1:0] OPR_SRL = 4'b0101;
  localparam logic [OPR_W-1:0] OPR_OR  = 4'b0110;
  localparam logic [OPR_W-1:0] OPR_AND = 4'b0111;
  // Branch / jump opcodes; anything at or above OPR_BEQ is control flow
  localparam logic [OPR_W-1:0] OPR_BEQ = 4'b1000;
  localparam logic [OPR_W-1:0] OPR_BNE = 4'b1001;
  localparam logic [OPR_W-1:0] OPR_BGE = 4'b1010;
  localparam logic [OPR_W-1:0] OPR_JAL = 4'b1011;

  typedef struct packed {
    logic              valid;
    logic [OPR_W-1:0]  opr;
    logic [XLEN-1:0]   op1;
    logic [XLEN-1:0]   op2;
    logic [REG_AW-1:0] rd;
    logic              we;
  } slot_t;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    SPLIT = 1'b1
  } state_e;

endpackage

// File: rtl/dual_issue_ex_latch_if.sv
// Decode-side pair, control and EX-side bundles of the dual-issue latch.
interface dual_issue_ex_latch_if;
  import rv_dual_pkg::*;

  logic              in_valid;
  logic              in_b_valid;
  logic              in_ready;
  logic [OPR_W-1:0]  a_opr;
  logic [OPR_W-1:0]  b_opr;
  logic [XLEN-1:0]   a_op1;
  logic [XLEN-1:0]   a_op2;
  logic [XLEN-1:0]   b_op1;
  logic [XLEN-1:0]   b_op2;
  logic [REG_AW-1:0] a_rd;
  logic [REG_AW-1:0] b_rd;
  logic              a_we;
  logic              b_we;
  logic [REG_AW-1:0] b_rs1;
  logic [REG_AW-1:0] b_rs2;
  logic              b_use1;
  logic              b_use2;
  logic [XLEN-1:0]   fwd_a_data;
  logic              stall;
  logic              flush;

  logic              exa_valid;
  logic [OPR_W-1:0]  exa_opr;
  logic [XLEN-1:0]   exa_op1;
  logic [XLEN-1:0]   exa_op2;
  logic [REG_AW-1:0] exa_rd;
  logic              exa_we;
  logic              exb_valid;
  logic [OPR_W-1:0]  exb_opr;
  logic [XLEN-1:0]   exb_op1;
  logic [XLEN-1:0]   exb_op2;
  logic [REG_AW-1:0] exb_rd;
  logic              exb_we;

  modport slave (
    input  in_valid, in_b_valid, a_opr, b_opr, a_op1, a_op2, b_op1, b_op2,
           a_rd, b_rd, a_we, b_we, b_rs1, b_rs2, b_use1, b_use2,
           fwd_a_data, stall, flush,
    output in_ready,
           exa_valid, exa_opr, exa_op1, exa_op2, exa_rd, exa_we,
           exb_valid, exb_opr, exb_op1, exb_op2, exb_rd, exb_we
  );

  modport master (
    output in_valid, in_b_valid, a_opr, b_opr, a_op1, a_op2, b_op1, b_op2,
           a_rd, b_rd, a_we, b_we, b_rs1, b_rs2, b_use1, b_use2,
           fwd_a_data, stall, flush,
    input  in_ready,
           exa_valid, exa_opr, exa_op1, exa_op2, exa_rd, exa_we,
           exb_valid, exb_opr, exb_op1, exb_op2, exb_rd, exb_we
  );
endinterface

// File: rtl/dual_issue_ex_latch_hazard.sv
// Intra-pair hazard detect: B reads A's destination, or B is control flow.
module dual_pair_hazard
  import rv_dual_pkg::*;
(
  input  logic [REG_AW-1:0] a_rd,
  input  logic              a_we,
  input  logic [REG_AW-1:0] b_rs1,
  input  logic [REG_AW-1:0] b_rs2,
  input  logic              b_use1,
  input  logic              b_use2,
  input  logic [OPR_W-1:0]  b_opr,
  output logic              dep1,
  output logic              dep2,
  output logic              split
);

  // x0 is never a real producer, so it cannot create a dependency
  assign dep1  = b_use1 & a_we & (a_rd != '0) & (b_rs1 == a_rd);
  assign dep2  = b_use2 & a_we & (a_rd != '0) & (b_rs2 == a_rd);
  assign split = dep1 | dep2 | (b_opr >= OPR_BEQ);

endmodule

// File: rtl/dual_issue_ex_latch.sv
// ID->EX pipeline register for a 2-way core; splits dependent or branch-B pairs.
module dual_issue_ex_latch
  import rv_dual_pkg::*;
(
  input logic                  clk,
  input logic                  reset,
  dual_issue_ex_latch_if.slave io
);

  state_e state_q, state_d;
  slot_t  exa_q, exa_d;
  slot_t  exb_q, exb_d;
  slot_t  held_q, held_d;
  logic   hdep1_q, hdep1_d;
  logic   hdep2_q, hdep2_d;

  logic   dep1_c, dep2_c, split_c;
  slot_t  a_slot_c, b_slot_c;

  dual_pair_hazard u_hazard (
    .a_rd   (io.a_rd),
    .a_we   (io.a_we),
    .b_rs1  (io.b_rs1),
    .b_rs2  (io.b_rs2),
    .b_use1 (io.b_use1),
    .b_use2 (io.b_use2),
    .b_opr  (io.b_opr),
    .dep1   (dep1_c),
    .dep2   (dep2_c),
    .split  (split_c)
  );

  assign a_slot_c = '{valid: 1'b1, opr: io.a_opr, op1: io.a_op1, op2: io.a_op2,
                      rd: io.a_rd, we: io.a_we};
  assign b_slot_c = '{valid: io.in_b_valid, opr: io.b_opr, op1: io.b_op1, op2: io.b_op2,
                      rd: io.b_rd, we: io.b_we & io.in_b_valid};

  assign io.in_ready = (state_q == RUN) & ~io.stall & ~io.flush;

  // Next-state: flush beats stall beats issue; SPLIT reissues held B on slot A
  always_comb begin
    state_d = state_q;
    exa_d   = exa_q;
    exb_d   = exb_q;
    held_d  = held_q;
    hdep1_d = hdep1_q;
    hdep2_d = hdep2_q;
    if (io.flush) begin
      exa_d.valid  = 1'b0;
      exa_d.we     = 1'b0;
      exb_d.valid  = 1'b0;
      exb_d.we     = 1'b0;
      held_d.valid = 1'b0;
      state_d      = RUN;
    end else if (!io.stall) begin
      case (state_q)
        RUN: begin
          if (io.in_valid) begin
            exa_d = a_slot_c;
            if (io.in_b_valid && split_c) begin
              exb_d.valid = 1'b0;
              exb_d.we    = 1'b0;
              held_d      = b_slot_c;
              hdep1_d     = dep1_c;
              hdep2_d     = dep2_c;
              state_d     = SPLIT;
            end else begin
              exb_d = b_slot_c;
            end
          end else begin
            exa_d.valid = 1'b0;
            exa_d.we    = 1'b0;
            exb_d.valid = 1'b0;
            exb_d.we    = 1'b0;
          end
        end
        SPLIT: begin
          // A is in EX now, so its result is on fwd_a_data this cycle
          exa_d        = held_q;
          exa_d.op1    = hdep1_q ? io.fwd_a_data : held_q.op1;
          exa_d.op2    = hdep2_q ? io.fwd_a_data : held_q.op2;
          exa_d.we     = held_q.we & held_q.valid;
          exb_d.valid  = 1'b0;
          exb_d.we     = 1'b0;
          held_d.valid = 1'b0;
          state_d      = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // State and bundle registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      exa_q   <= '0;
      exb_q   <= '0;
      held_q  <= '0;
      hdep1_q <= 1'b0;
      hdep2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      exa_q   <= exa_d;
      exb_q   <= exb_d;
      held_q  <= held_d;
      hdep1_q <= hdep1_d;
      hdep2_q <= hdep2_d;
    end
  end

  assign io.exa_valid = exa_q.valid;
  assign io.exa_opr   = exa_q.opr;
  assign io.exa_op1   = exa_q.op1;
  assign io.exa_op2   = exa_q.op2;
  assign io.exa_rd    = exa_q.rd;
  assign io.exa_we    = exa_q.we;
  assign io.exb_valid = exb_q.valid;
  assign io.exb_opr   = exb_q.opr;
  assign io.exb_op1   = exb_q.op1;
  assign io.exb_op2   = exb_q.op2;
  assign io.exb_rd    = exb_q.rd;
  assign io.exb_we    = exb_q.we;

endmodule

// File: tb/tb_dual_issue_ex_latch.sv
// Bench for dual_issue_ex_latch: directed scenarios plus random pairs vs. a pair-level model.
module tb_dual_issue_ex_latch;
  import rv_dual_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_pass = 0;

  dual_issue_ex_latch_if bus ();

  dual_issue_ex_latch u_dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  always #5 clk = ~clk;

  // Model: what EX should hold, plus the one instruction waiting for its second cycle
  slot_t      m_a, m_b, m_pend;
  bit         m_pending;
  bit         m_fwd1, m_fwd2;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic bit reads_reg(input logic use_r, input logic [4:0] rs,
                                   input logic [4:0] rd, input logic we);
    return use_r && we && rd != 5'd0 && rs == rd;
  endfunction

  task automatic model_reset();
    m_a = '0; m_b = '0; m_pend = '0;
    m_pending = 0; m_fwd1 = 0; m_fwd2 = 0;
  endtask

  // Apply one clock edge to the model using the inputs currently driven
  task automatic model_edge();
    bit d1, d2;
    if (bus.flush) begin
      m_a.valid = 0; m_a.we = 0; m_b.valid = 0; m_b.we = 0;
      m_pending = 0;
    end else if (bus.stall) begin
      // nothing moves
    end else if (m_pending) begin
      m_a = m_pend;
      if (m_fwd1) m_a.op1 = bus.fwd_a_data;
      if (m_fwd2) m_a.op2 = bus.fwd_a_data;
      m_b.valid = 0; m_b.we = 0;
      m_pending = 0;
    end else if (bus.in_valid) begin
      m_a = '{valid: 1'b1, opr: bus.a_opr, op1: bus.a_op1, op2: bus.a_op2,
              rd: bus.a_rd, we: bus.a_we};
      d1 = reads_reg(bus.b_use1, bus.b_rs1, bus.a_rd, bus.a_we);
      d2 = reads_reg(bus.b_use2, bus.b_rs2, bus.a_rd, bus.a_we);
      if (bus.in_b_valid && (d1 || d2 || int'(bus.b_opr) >= 8)) begin
        m_pend = '{valid: 1'b1, opr: bus.b_opr, op1: bus.b_op1, op2: bus.b_op2,
                   rd: bus.b_rd, we: bus.b_we};
        m_fwd1 = d1; m_fwd2 = d2; m_pending = 1;
        m_b.valid = 0; m_b.we = 0;
      end else begin
        m_b = '{valid: bus.in_b_valid, opr: bus.b_opr, op1: bus.b_op1, op2: bus.b_op2,
                rd: bus.b_rd, we: bus.b_we && bus.in_b_valid};
      end
    end else begin
      m_a.valid = 0; m_a.we = 0; m_b.valid = 0; m_b.we = 0;
    end
  endtask

  task automatic check_outputs();
    chk("exa_valid", 64'(bus.exa_valid), 64'(m_a.valid));
    chk("exa_we",    64'(bus.exa_we),    64'(m_a.we));
    chk("exb_valid", 64'(bus.exb_valid), 64'(m_b.valid));
    chk("exb_we",    64'(bus.exb_we),    64'(m_b.we));
    if (m_a.valid) begin
      chk("exa_opr", 64'(bus.exa_opr), 64'(m_a.opr));
      chk("exa_op1", bus.exa_op1, m_a.op1);
      chk("exa_op2", bus.exa_op2, m_a.op2);
      chk("exa_rd",  64'(bus.exa_rd),  64'(m_a.rd));
    end
    if (m_b.valid) begin
      chk("exb_opr", 64'(bus.exb_opr), 64'(m_b.opr));
      chk("exb_op1", bus.exb_op1, m_b.op1);
      chk("exb_op2", bus.exb_op2, m_b.op2);
      chk("exb_rd",  64'(bus.exb_rd),  64'(m_b.rd));
    end
  endtask

  // Inputs are set just after negedge; check ready, take the edge, check EX bundles
  task automatic cycle();
    #1;
    chk("in_ready", 64'(bus.in_ready), 64'(!m_pending && !bus.stall && !bus.flush));
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    bus.in_valid = 0; bus.in_b_valid = 0;
    bus.a_opr = '0; bus.b_opr = '0;
    bus.a_op1 = '0; bus.a_op2 = '0; bus.b_op1 = '0; bus.b_op2 = '0;
    bus.a_rd = '0; bus.b_rd = '0; bus.a_we = 0; bus.b_we = 0;
    bus.b_rs1 = '0; bus.b_rs2 = '0; bus.b_use1 = 0; bus.b_use2 = 0;
    bus.fwd_a_data = '0; bus.stall = 0; bus.flush = 0;
  endtask

  task automatic set_pair(input logic [3:0] ao, input logic [4:0] ard, input logic awe,
                          input logic [3:0] bo, input logic [4:0] brd, input logic bwe,
                          input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2);
    bus.in_valid = 1; bus.in_b_valid = 1; bus.stall = 0; bus.flush = 0;
    bus.a_opr = ao; bus.a_rd = ard; bus.a_we = awe;
    bus.b_opr = bo; bus.b_rd = brd; bus.b_we = bwe;
    bus.b_rs1 = rs1; bus.b_rs2 = rs2; bus.b_use1 = u1; bus.b_use2 = u2;
    bus.a_op1 = {$urandom, $urandom}; bus.a_op2 = {$urandom, $urandom};
    bus.b_op1 = {$urandom, $urandom}; bus.b_op2 = {$urandom, $urandom};
    bus.fwd_a_data = {$urandom, $urandom};
  endtask

  task automatic drive_rand();
    bus.in_valid   = ($urandom_range(0, 4) != 0);
    bus.in_b_valid = ($urandom_range(0, 3) != 0);
    bus.a_opr = 4'($urandom_range(0, 11));
    bus.b_opr = 4'($urandom_range(0, 11));
    bus.a_op1 = {$urandom, $urandom}; bus.a_op2 = {$urandom, $urandom};
    bus.b_op1 = {$urandom, $urandom}; bus.b_op2 = {$urandom, $urandom};
    bus.a_rd  = 5'($urandom_range(0, 3)); bus.b_rd  = 5'($urandom_range(0, 3));
    bus.b_rs1 = 5'($urandom_range(0, 3)); bus.b_rs2 = 5'($urandom_range(0, 3));
    bus.a_we  = 1'($urandom); bus.b_we = 1'($urandom);
    bus.b_use1 = 1'($urandom); bus.b_use2 = 1'($urandom);
    bus.fwd_a_data = {$urandom, $urandom};
    bus.stall = ($urandom_range(0, 5) == 0);
    bus.flush = ($urandom_range(0, 9) == 0);
  endtask

  initial begin
    drive_idle();
    model_reset();
    reset = 1'b1;
    #12;
    check_outputs();
    chk("rst_exa_opr", 64'(bus.exa_opr), 64'd0);
    chk("rst_exa_op1", bus.exa_op1, 64'd0);
    chk("rst_exb_rd",  64'(bus.exb_rd), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // T1: independent add x3 / sub x4
    set_pair(OPR_ADD, 5'd3, 1, OPR_SUB, 5'd4, 1, 5'd1, 5'd2, 1, 1);
    cycle();
    chk("t1_exa_opr", 64'(bus.exa_opr), 64'd0);
    chk("t1_exb_opr", 64'(bus.exb_opr), 64'd1);
    chk("t1_exb_valid", 64'(bus.exb_valid), 64'd1);

    // T2: B reads x5 written by A; forwarded 0x2A lands on op1
    set_pair(OPR_ADD, 5'd5, 1, OPR_ADD, 5'd6, 1, 5'd5, 5'd7, 1, 1);
    cycle();
    chk("t2_exb_hold", 64'(bus.exb_valid), 64'd0);
    bus.fwd_a_data = 64'h2A;
    cycle();
    chk("t2_exa_op1", bus.exa_op1, 64'h2A);
    chk("t2_exa_rd",  64'(bus.exa_rd), 64'd6);

    // T3: B is beq with no dependency
    set_pair(OPR_XOR, 5'd8, 1, OPR_BEQ, 5'd0, 0, 5'd1, 5'd2, 1, 1);
    cycle();
    cycle();
    chk("t3_exa_opr", 64'(bus.exa_opr), 64'h8);

    // T4: split pending, then flush
    set_pair(OPR_ADD, 5'd5, 1, OPR_ADD, 5'd6, 1, 5'd5, 5'd7, 1, 0);
    cycle();
    bus.flush = 1;
    cycle();
    bus.flush = 0; bus.in_valid = 0;
    cycle();
    chk("t4_no_reissue", 64'(bus.exa_valid), 64'd0);

    // T5: three stall cycles mid-split
    set_pair(OPR_ADD, 5'd9, 1, OPR_OR, 5'd10, 1, 5'd2, 5'd9, 1, 1);
    cycle();
    bus.stall = 1;
    repeat (3) begin
      bus.fwd_a_data = {$urandom, $urandom};
      cycle();
    end
    bus.stall = 0;
    bus.fwd_a_data = 64'h1234_5678_9ABC_DEF0;
    cycle();
    chk("t5_exa_op2", bus.exa_op2, 64'h1234_5678_9ABC_DEF0);

    // T6: x0 never a dependency; WAW does not split
    set_pair(OPR_ADD, 5'd0, 1, OPR_SUB, 5'd2, 1, 5'd0, 5'd0, 1, 1);
    cycle();
    chk("t6_x0_b_valid", 64'(bus.exb_valid), 64'd1);
    set_pair(OPR_ADD, 5'd9, 1, OPR_SUB, 5'd9, 1, 5'd1, 5'd2, 1, 1);
    cycle();
    chk("t6_waw_b_valid", 64'(bus.exb_valid), 64'd1);

    // Random pairs
    for (int i = 0; i < 600; i++) begin
      drive_rand();
      cycle();
    end

    // Asynchronous reset while a split is pending
    set_pair(OPR_ADD, 5'd5, 1, OPR_ADD, 5'd6, 1, 5'd5, 5'd7, 1, 1);
    cycle();
    #3 reset = 1'b1;
    #1;
    model_reset();
    check_outputs();
    chk("arst_exa_rd", 64'(bus.exa_rd), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    drive_idle();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
